// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_scoreboard_unit                                                   |
// | Per-register countdown interlock: load-use / flag-use stalls, flush seq. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_scoreboard_unit #(
    parameter int NUM_REGS  = 16,
    parameter int LOAD_LAT  = 1,
    parameter int FLAG_LAT  = 2,
    parameter int FLUSH_CYC = 1,
    parameter int ZERO_REG  = 1,
    parameter int CNT_W     = 3,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_rs_addr,
    input  logic                id_rs_used,
    input  logic [ADDR_W-1:0]   id_rt_addr,
    input  logic                id_rt_used,
    input  logic [ADDR_W-1:0]   id_rd_addr,
    input  logic                id_rd_write,
    input  logic                id_is_load,
    input  logic                id_sets_flags,
    input  logic                id_uses_flags,
    input  logic                ex_br_taken,
    input  logic                mem_stall,
    output logic                stall,
    output logic                if_flush,
    output logic                id_flush,
    output logic [NUM_REGS-1:0] busy_map
);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    localparam int c_FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_RELOAD = c_FLUSH_W'(FLUSH_CYC - 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE    = c_FLUSH_W'(1);
    localparam logic [CNT_W-1:0]     c_LOAD_LAT     = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0]     c_FLAG_LAT     = CNT_W'(FLAG_LAT);
    localparam logic [CNT_W-1:0]     c_CNT_ONE      = CNT_W'(1);

    logic [0:0]           r_state;
    logic [0:0]           w_stateNext;
    logic [c_FLUSH_W-1:0] r_flushCnt;
    logic [c_FLUSH_W-1:0] w_flushCntNext;
    logic [CNT_W-1:0]     r_flagCnt;
    logic [NUM_REGS-1:0]  w_busy;
    logic                 w_haz;
    logic                 w_issue;
    logic                 w_loadIssue;
    logic                 w_aluIssue;

    assign if_flush = ex_br_taken | (r_state == c_ST_FLUSH);
    assign w_haz    = id_valid & ((id_rs_used & w_busy[id_rs_addr]) |
                                  (id_rt_used & w_busy[id_rt_addr]) |
                                  (id_uses_flags & (r_flagCnt != '0)));
    // A squashed instruction never needs to wait, so flush masks the stall.
    assign stall    = w_haz & ~if_flush;
    assign id_flush = stall | if_flush;
    assign busy_map = w_busy;

    assign w_issue     = id_valid & ~stall & ~if_flush & ~mem_stall;
    assign w_loadIssue = w_issue & id_rd_write & id_is_load;
    assign w_aluIssue  = w_issue & id_rd_write & ~id_is_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_flushCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_flushCnt <= w_flushCntNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_flushCntNext = r_flushCnt;
        if (!mem_stall) begin
            case (r_state)
                c_ST_RUN: begin
                    if (ex_br_taken) begin
                        w_stateNext    = c_ST_FLUSH;
                        w_flushCntNext = c_FLUSH_RELOAD;
                    end
                end
                c_ST_FLUSH: begin
                    if (ex_br_taken) begin
                        w_flushCntNext = c_FLUSH_RELOAD;
                    end else if (r_flushCnt == '0) begin
                        w_stateNext = c_ST_RUN;
                    end else begin
                        w_flushCntNext = r_flushCnt - c_FLUSH_ONE;
                    end
                end
                default: begin
                    w_stateNext    = c_ST_RUN;
                    w_flushCntNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flagCnt <= '0;
        end else if (!mem_stall) begin
            if (w_issue & id_sets_flags) begin
                r_flagCnt <= c_FLAG_LAT;
            end else if (r_flagCnt != '0) begin
                r_flagCnt <= r_flagCnt - c_CNT_ONE;
            end
        end
    end

    for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_reg
        if ((ZERO_REG != 0) && (gr == 0)) begin : g_zero
            assign w_busy[gr] = 1'b0;
        end else begin : g_track
            logic [CNT_W-1:0] r_cnt;
            logic             w_hit;
            assign w_hit      = (id_rd_addr == ADDR_W'(gr));
            assign w_busy[gr] = (r_cnt != '0);
            // Issue overrides the countdown; an ALU write forwards, so it clears any older load.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (!mem_stall) begin
                    if (w_loadIssue & w_hit) begin
                        r_cnt <= c_LOAD_LAT;
                    end else if (w_aluIssue & w_hit) begin
                        r_cnt <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
            end
        end
    end

    a_noStallDuringFlush: assert property (@(posedge clk) disable iff (rst) !(stall && if_flush));

endmodule
`default_nettype wire
